// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder sequencer. A single one-bit full-adder cell is time-shared
// to add two WIDTH-bit operands LSB first, one bit per clock. The block holds
// the operand shift registers, the carry flop, the bit counter and a
// start/busy/done handshake toward the requester.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   Defined   -> adds the 'sub' input; sub=1 computes a - b (two's complement,
//                cout=1 means no borrow). sub=0 behaves exactly as add.
//   Undefined -> add only, no 'sub' port.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous active-high reset (aborts any operation)
//   start  in   1      request, honoured only in IDLE or DONE
//   sub    in   1      (SERIAL_ADD_SUB_EN only) subtract select
//   a, b   in   WIDTH  operands, captured on an accepted start
//   cin    in   1      carry-in, captured on an accepted start
//   busy   out  1      high for the WIDTH bit-processing cycles
//   done   out  1      one-cycle pulse, sum/cout valid in the same cycle
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      registered final carry, held with sum
//
// Latency: accept at edge T -> done high in the cycle after edge T+WIDTH.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-bit full-adder cell shared across all bit positions.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (c & (x ^ y));
  endfunction

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] rs;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             step;
  logic             last_bit;
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Operand conditioning at capture time: subtract is a + ~b + 1.
  always_comb begin
    b_load     = b;
    carry_load = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_load     = ~b;
      carry_load = 1'b1;
    end else begin
      b_load     = b;
      carry_load = cin;
    end
`endif
  end

  // Next-state and control decode; start is honoured only in IDLE and DONE.
  always_comb begin
    state_next = IDLE;
    accept     = 1'b0;
    step       = 1'b0;
    last_bit   = (cnt == CNT_W'(WIDTH - 1));
    bit_s      = fa_sum(sa[0], sb[0], carry);
    bit_c      = fa_carry(sa[0], sb[0], carry);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand/result shift registers, carry flop and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= {WIDTH{1'b0}};
      sb    <= {WIDTH{1'b0}};
      rs    <= {WIDTH{1'b0}};
      carry <= 1'b0;
      cnt   <= {CNT_W{1'b0}};
    end else if (accept) begin
      sa    <= a;
      sb    <= b_load;
      rs    <= {WIDTH{1'b0}};
      carry <= carry_load;
      cnt   <= {CNT_W{1'b0}};
    end else if (step) begin
      sa    <= {1'b0, sa[WIDTH-1:1]};
      sb    <= {1'b0, sb[WIDTH-1:1]};
      rs    <= {bit_s, rs[WIDTH-1:1]};
      carry <= bit_c;
      cnt   <= cnt + CNT_W'(1);
    end else begin
      sa    <= sa;
      sb    <= sb;
      rs    <= rs;
      carry <= carry;
      cnt   <= cnt;
    end
  end

  // Result registers: loaded on the edge entering DONE, including the final
  // bit and carry produced in that same cycle, so they line up with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= {WIDTH{1'b0}};
      cout <= 1'b0;
    end else if (step && last_bit) begin
      sum  <= {bit_s, rs[WIDTH-1:1]};
      cout <= bit_c;
    end else begin
      sum  <= sum;
      cout <= cout;
    end
  end

  // Handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed plus randomized bench for serial_add_ctrl (WIDTH=8). Expected
// results come from plain integer arithmetic on the operands; handshake
// timing is checked cycle by cycle against the documented latency.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int           n_vec;
  int           n_err;
  logic [W-1:0] held_sum;
  logic         held_cout;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout,sum} = a + b + cin.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return (W+1)'(t);
  endfunction

  // Reference: sum = a - b mod 2^W, cout = no borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    int t;
    logic no_borrow;
    t = int'(x) - int'(y);
    no_borrow = (x >= y);
    return {no_borrow, W'(t)};
  endfunction

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic is);
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
`ifdef SERIAL_ADD_SUB_EN
    sub   = is;
`else
    if (is) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
    tick();
    start = 1'b0;
  endtask

  // Called one cycle after the accepting edge. Walks the W busy cycles, then
  // checks the done cycle. 'disturb' re-pulses start and scrambles operands.
  task automatic expect_run(input logic [W:0] exp, input bit disturb);
    for (int i = 0; i < W; i++) begin
      check("busy_run", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
      check("done_run", {{W{1'b0}}, done}, {(W+1){1'b0}});
      check("sum_hold", {cout, sum}, {held_cout, held_sum});
      if (disturb && i == 3) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
      end
      if (disturb && i == 4) start = 1'b0;
      tick();
    end
    check("busy_at_done", {{W{1'b0}}, busy}, {(W+1){1'b0}});
    check("done_pulse", {{W{1'b0}}, done}, {{W{1'b0}}, 1'b1});
    check("result", {cout, sum}, exp);
    held_sum  = exp[W-1:0];
    held_cout = exp[W];
  endtask

  task automatic expect_idle();
    tick();
    check("done_clear", {{W{1'b0}}, done}, {(W+1){1'b0}});
    check("busy_idle", {{W{1'b0}}, busy}, {(W+1){1'b0}});
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub       = 1'b0;
`endif
    held_sum  = '0;
    held_cout = 1'b0;

    tick();
    tick();
    check("reset_busy", {{W{1'b0}}, busy}, {(W+1){1'b0}});
    check("reset_done", {{W{1'b0}}, done}, {(W+1){1'b0}});
    check("reset_result", {cout, sum}, {(W+1){1'b0}});
    rst = 1'b0;
    tick();

    // Basic add.
    issue(8'h3C, 8'h5A, 1'b0, 1'b0);
    expect_run(ref_add(8'h3C, 8'h5A, 1'b0), 1'b0);
    expect_idle();

    // Carry-out cases.
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    expect_run(ref_add(8'hFF, 8'h01, 1'b0), 1'b0);
    expect_idle();
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);
    expect_run(ref_add(8'hFF, 8'hFF, 1'b1), 1'b0);
    expect_idle();

    // Back-to-back: start held high across both operations.
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    cin   = 1'b0;
    tick();
    a     = 8'h10;
    b     = 8'h20;
    expect_run(ref_add(8'h01, 8'h02, 1'b0), 1'b0);
    tick();
    start = 1'b0;
    expect_run(ref_add(8'h10, 8'h20, 1'b0), 1'b0);
    expect_idle();

    // start re-pulsed and operands changed mid-RUN: ignored.
    issue(8'h3C, 8'h5A, 1'b0, 1'b0);
    expect_run(ref_add(8'h3C, 8'h5A, 1'b0), 1'b1);
    expect_idle();
    for (int i = 0; i < 3; i++) expect_idle();

    // Reset in RUN cycle 4 aborts the operation.
    issue(8'h3C, 8'h5A, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {{W{1'b0}}, busy}, {(W+1){1'b0}});
    check("abort_done", {{W{1'b0}}, done}, {(W+1){1'b0}});
    check("abort_result", {cout, sum}, {(W+1){1'b0}});
    held_sum  = '0;
    held_cout = 1'b0;
    expect_idle();
    issue(8'h07, 8'h09, 1'b0, 1'b0);
    expect_run(ref_add(8'h07, 8'h09, 1'b0), 1'b0);
    expect_idle();

`ifdef SERIAL_ADD_SUB_EN
    issue(8'h10, 8'h01, 1'b0, 1'b1);
    expect_run(ref_sub(8'h10, 8'h01), 1'b0);
    expect_idle();
    issue(8'h01, 8'h02, 1'b1, 1'b1);
    expect_run(ref_sub(8'h01, 8'h02), 1'b0);
    expect_idle();
`endif

    // Randomized operations with random idle gaps.
    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      if ($urandom_range(0, 1) == 1) begin
        issue(ra, rb, rc, 1'b1);
        expect_run(ref_sub(ra, rb), 1'b0);
      end else begin
        issue(ra, rb, rc, 1'b0);
        expect_run(ref_add(ra, rb, rc), 1'b0);
      end
`else
      issue(ra, rb, rc, 1'b0);
      expect_run(ref_add(ra, rb, rc), 1'b0);
`endif
      expect_idle();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
